// File: rtl/mem_access_ctrl_pkg.sv
// Shared opcodes, FSM state and access bundle for the CPU load/store bus bridge.
// Lane steering helpers live here so the top and the bench-free units agree on them.
package mem_access_ctrl_pkg;

    localparam logic [5:0] OPCODE_LB  = 6'h20;
    localparam logic [5:0] OPCODE_LH  = 6'h21;
    localparam logic [5:0] OPCODE_LW  = 6'h23;
    localparam logic [5:0] OPCODE_LBU = 6'h24;
    localparam logic [5:0] OPCODE_LHU = 6'h25;
    localparam logic [5:0] OPCODE_SB  = 6'h28;
    localparam logic [5:0] OPCODE_SH  = 6'h29;
    localparam logic [5:0] OPCODE_SW  = 6'h2B;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUS   = 2'd1,
        RDATA = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [5:0]  opcode;
        logic        is_read;
    } acc_t;

    function automatic logic is_byte_op(input logic [5:0] op);
        return (op == OPCODE_LB) || (op == OPCODE_LBU) || (op == OPCODE_SB);
    endfunction

    function automatic logic is_half_op(input logic [5:0] op);
        return (op == OPCODE_LH) || (op == OPCODE_LHU) || (op == OPCODE_SH);
    endfunction

    function automatic logic is_load(input logic [5:0] op);
        return (op == OPCODE_LB) || (op == OPCODE_LBU) ||
               (op == OPCODE_LH) || (op == OPCODE_LHU) ||
               (op == OPCODE_LW);
    endfunction

    function automatic logic is_store(input logic [5:0] op);
        return (op == OPCODE_SB) || (op == OPCODE_SH) || (op == OPCODE_SW);
    endfunction

    function automatic logic [3:0] lane_enable(input logic [5:0] op,
                                               input logic [1:0] a);
        logic [3:0] be;
        be = 4'b1111;
        unique case (1'b1)
            is_byte_op(op): be = 4'b0001 << a;
            is_half_op(op): be = a[1] ? 4'b1100 : 4'b0011;
            default:        be = 4'b1111;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] lane_data(input logic [5:0] op,
                                              input logic [31:0] wd);
        logic [31:0] d;
        d = '0;
        unique case (1'b1)
            op == OPCODE_SB: d = {4{wd[7:0]}};
            op == OPCODE_SH: d = {2{wd[15:0]}};
            op == OPCODE_SW: d = wd;
            default:         d = '0;
        endcase
        return d;
    endfunction

    function automatic logic misaligned(input logic [5:0] op,
                                        input logic [1:0] a);
        logic bad;
        bad = 1'b0;
        unique case (1'b1)
            is_half_op(op):                       bad = a[0];
            (op == OPCODE_LW) || (op == OPCODE_SW): bad = (a != 2'b00);
            default:                              bad = 1'b0;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// CPU request/response and Avalon-MM master signals of the load/store bridge.
// slave = the controller, master = the CPU plus bus slave environment.
interface mem_access_ctrl_if;

    logic        req_valid;
    logic [5:0]  req_opcode;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        req_ready;

    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;

    logic [31:0] avm_address;
    logic        avm_read;
    logic        avm_write;
    logic [3:0]  avm_byteenable;
    logic [31:0] avm_writedata;
    logic        avm_waitrequest;
    logic [31:0] avm_readdata;

    modport slave (
        input  req_valid, req_opcode, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output avm_address, avm_read, avm_write,
        output avm_byteenable, avm_writedata,
        input  avm_waitrequest, avm_readdata
    );

    modport master (
        output req_valid, req_opcode, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  avm_address, avm_read, avm_write,
        input  avm_byteenable, avm_writedata,
        output avm_waitrequest, avm_readdata
    );

endinterface

// File: rtl/mem_access_ctrl_load_extend.sv
// Picks the addressed lane out of a read word and sign/zero extends it.
// Word loads pass through; half loads look only at addr[1].
module load_extend
    import mem_access_ctrl_pkg::*;
(
    input  logic [31:0] readdata,
    input  logic [5:0]  opcode,
    input  logic [1:0]  addr,
    output logic [31:0] result
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    assign byte_lane = readdata[{addr, 3'b000} +: 8];
    assign half_lane = addr[1] ? readdata[31:16] : readdata[15:0];

    always_comb begin
        result = '0;
        unique case (1'b1)
            opcode == OPCODE_LB:  result = {{24{byte_lane[7]}}, byte_lane};
            opcode == OPCODE_LBU: result = {24'b0, byte_lane};
            opcode == OPCODE_LH:  result = {{16{half_lane[15]}}, half_lane};
            opcode == OPCODE_LHU: result = {16'b0, half_lane};
            opcode == OPCODE_LW:  result = readdata;
            default:              result = '0;
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// Single-outstanding MIPS load/store to Avalon-MM bridge with optional wait timeout.
// Define MEM_ALIGN_TRAP_EN to reject misaligned half/word accesses without a bus cycle.
module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
#(
    parameter int unsigned WAIT_LIMIT = 0
) (
    input  logic              clk,
    input  logic              reset,
    mem_access_ctrl_if.slave  bus
);

    localparam logic [31:0] LIMIT_M1 = WAIT_LIMIT - 1;

    state_t      state;
    state_t      state_next;
    acc_t        acc;
    logic [31:0] rdata_q;
    logic        err_q;
    logic [31:0] wait_cnt;

    logic        accept;
    logic        supported;
    logic        trap;
    logic        timeout;
    logic [31:0] ext_result;

    assign accept    = bus.req_valid && (state == IDLE);
    assign supported = is_load(bus.req_opcode) || is_store(bus.req_opcode);

`ifdef MEM_ALIGN_TRAP_EN
    assign trap = supported && misaligned(bus.req_opcode, bus.req_addr[1:0]);
`else
    assign trap = 1'b0;
`endif

    // Fires on the BUS edge that would complete the WAIT_LIMIT-th stalled cycle.
    assign timeout = (WAIT_LIMIT != 0) && (state == BUS)
                     && bus.avm_waitrequest && (wait_cnt == LIMIT_M1);

    load_extend u_load_extend (
        .readdata (bus.avm_readdata),
        .opcode   (acc.opcode),
        .addr     (acc.addr[1:0]),
        .result   (ext_result)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_next = (supported && !trap) ? BUS : DONE;
                end
            end
            BUS: begin
                if (!bus.avm_waitrequest) begin
                    state_next = acc.is_read ? RDATA : DONE;
                end else if (timeout) begin
                    state_next = DONE;
                end
            end
            RDATA:   state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready      = (state == IDLE);
        bus.resp_valid     = (state == DONE);
        bus.resp_rdata     = rdata_q;
        bus.resp_err       = err_q;
        bus.avm_read       = (state == BUS) && acc.is_read;
        bus.avm_write      = (state == BUS) && !acc.is_read;
        bus.avm_address    = {acc.addr[31:2], 2'b00};
        bus.avm_byteenable = acc.be;
        bus.avm_writedata  = acc.wdata;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc      <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
            wait_cnt <= '0;
        end else begin
            if (accept) begin
                acc.addr    <= bus.req_addr;
                acc.be      <= lane_enable(bus.req_opcode, bus.req_addr[1:0]);
                acc.wdata   <= lane_data(bus.req_opcode, bus.req_wdata);
                acc.opcode  <= bus.req_opcode;
                acc.is_read <= is_load(bus.req_opcode);
                rdata_q     <= '0;
                err_q       <= trap;
                wait_cnt    <= '0;
            end
            if (state == BUS) begin
                wait_cnt <= bus.avm_waitrequest ? wait_cnt + 32'd1 : '0;
                if (timeout) begin
                    err_q <= 1'b1;
                end
            end
            if (state == RDATA) begin
                rdata_q <= ext_result;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: directed cases then random traffic
// against a size/offset arithmetic model of the load/store bridge.
module tb_mem_access_ctrl;

    localparam int WL = 4;

    localparam logic [5:0] LB  = 6'h20;
    localparam logic [5:0] LH  = 6'h21;
    localparam logic [5:0] LW  = 6'h23;
    localparam logic [5:0] LBU = 6'h24;
    localparam logic [5:0] LHU = 6'h25;
    localparam logic [5:0] SB  = 6'h28;
    localparam logic [5:0] SH  = 6'h29;
    localparam logic [5:0] SW  = 6'h2B;
    localparam logic [5:0] BAD = 6'h22;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    mem_access_ctrl_if bus();

    mem_access_ctrl #(.WAIT_LIMIT(WL)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int size_of(input logic [5:0] op);
        if (op == LB || op == LBU || op == SB) return 1;
        if (op == LH || op == LHU || op == SH) return 2;
        if (op == LW || op == SW) return 4;
        return 0;
    endfunction

    function automatic bit is_rd(input logic [5:0] op);
        return op == LB || op == LBU || op == LH || op == LHU || op == LW;
    endfunction

    function automatic bit trap_of(input logic [5:0] op, input logic [31:0] a);
        int sz;
        sz = size_of(op);
`ifdef MEM_ALIGN_TRAP_EN
        return sz > 1 && (int'(a[1:0]) % sz) != 0;
`else
        return (sz < 0) && a[0];
`endif
    endfunction

    // Offset of the addressed item rounded down to its natural size.
    function automatic int off_of(input logic [5:0] op, input logic [31:0] a);
        int lo;
        int sz;
        lo = int'(a[1:0]);
        sz = size_of(op);
        return lo - lo % sz;
    endfunction

    function automatic logic [3:0] model_be(input logic [5:0] op,
                                            input logic [31:0] a);
        logic [3:0] m;
        m = 4'((1 << size_of(op)) - 1);
        return m << off_of(op, a);
    endfunction

    function automatic logic [31:0] model_wd(input logic [5:0] op,
                                             input logic [31:0] wd);
        logic [31:0] o;
        int sz;
        sz = size_of(op);
        o = '0;
        for (int i = 0; i < 4; i++) o[8*i +: 8] = wd[8*(i % sz) +: 8];
        return o;
    endfunction

    function automatic logic [31:0] model_ld(input logic [5:0] op,
                                             input logic [31:0] a,
                                             input logic [31:0] rd);
        logic [63:0] v;
        logic [63:0] mask;
        int sz;
        sz = size_of(op);
        v = {32'b0, rd} >> (8 * off_of(op, a));
        mask = (64'd1 << (8 * sz)) - 64'd1;
        v = v & mask;
        if ((op == LB || op == LH) && v[8*sz-1]) v = v | ~mask;
        return v[31:0];
    endfunction

    task automatic do_access(input string tag, input logic [5:0] op,
                             input logic [31:0] a, input logic [31:0] wd,
                             input logic [31:0] rd, input int nw);
        int sz;
        bit uses_bus;
        int exp_lat;
        int exp_strb;
        bit exp_err;
        logic [31:0] exp_rd;
        int cyc;
        int strb;
        bit give_rd;
        bit done;
        sz = size_of(op);
        uses_bus = (sz != 0) && !trap_of(op, a);
        if (!uses_bus) begin
            exp_lat = 1; exp_strb = 0; exp_err = trap_of(op, a); exp_rd = '0;
        end else if (nw >= WL) begin
            exp_lat = WL + 1; exp_strb = WL; exp_err = 1'b1; exp_rd = '0;
        end else begin
            exp_strb = nw + 1;
            exp_lat = is_rd(op) ? nw + 3 : nw + 2;
            exp_err = 1'b0;
            exp_rd = is_rd(op) ? model_ld(op, a, rd) : '0;
        end
        chk({tag, " ready"}, 32'(bus.req_ready), 32'd1);
        bus.req_valid = 1'b1;
        bus.req_opcode = op;
        bus.req_addr = a;
        bus.req_wdata = wd;
        bus.avm_waitrequest = 1'b0;
        @(negedge clk);
        cyc = 1; strb = 0; give_rd = 1'b0; done = 1'b0;
        while (!done && cyc <= 40) begin
            bus.req_valid = 1'($urandom_range(0, 1));
            bus.req_opcode = 6'($urandom);
            bus.req_addr = $urandom;
            bus.req_wdata = $urandom;
            bus.avm_readdata = give_rd ? rd : $urandom;
            give_rd = 1'b0;
            bus.avm_waitrequest = 1'b0;
            if (bus.avm_read || bus.avm_write) begin
                strb++;
                chk({tag, " strobe"}, 32'({bus.avm_read, bus.avm_write}),
                    is_rd(op) ? 32'd2 : 32'd1);
                chk({tag, " addr"}, bus.avm_address, a & ~32'd3);
                chk({tag, " be"}, 32'(bus.avm_byteenable), 32'(model_be(op, a)));
                if (!is_rd(op)) chk({tag, " wdata"}, bus.avm_writedata, model_wd(op, wd));
                bus.avm_waitrequest = (strb <= nw);
                give_rd = (strb > nw) && is_rd(op);
            end
            if (bus.resp_valid) begin
                done = 1'b1;
                chk({tag, " latency"}, 32'(cyc), 32'(exp_lat));
                chk({tag, " rdata"}, bus.resp_rdata, exp_rd);
                chk({tag, " err"}, 32'(bus.resp_err), 32'(exp_err));
                chk({tag, " strobes"}, 32'(strb), 32'(exp_strb));
            end else begin
                @(negedge clk);
                cyc++;
            end
        end
        if (!done) chk({tag, " resp_bound"}, 32'd0, 32'd1);
        @(negedge clk);
        chk({tag, " pulse"}, 32'(bus.resp_valid), 32'd0);
        bus.req_valid = 1'b0;
        bus.avm_waitrequest = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " ready"}, 32'(bus.req_ready), 32'd1);
        chk({tag, " rvalid"}, 32'(bus.resp_valid), 32'd0);
        chk({tag, " rerr"}, 32'(bus.resp_err), 32'd0);
        chk({tag, " rdata"}, bus.resp_rdata, 32'd0);
        chk({tag, " rd_wr"}, 32'({bus.avm_read, bus.avm_write}), 32'd0);
        chk({tag, " be"}, 32'(bus.avm_byteenable), 32'd0);
        chk({tag, " addr"}, bus.avm_address, 32'd0);
        chk({tag, " wdata"}, bus.avm_writedata, 32'd0);
    endtask

    logic [5:0] ops [9];

    initial begin
        ops = '{LB, LBU, LH, LHU, LW, SB, SH, SW, BAD};
        reset = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_opcode = '0;
        bus.req_addr = '0;
        bus.req_wdata = '0;
        bus.avm_waitrequest = 1'b0;
        bus.avm_readdata = '0;
        repeat (2) @(negedge clk);
        chk_reset_vals("reset0");
        reset = 1'b0;
        @(negedge clk);

        do_access("lb_103", LB, 32'h103, 32'h0, 32'h80FF0000, 0);
        do_access("lhu_102", LHU, 32'h102, 32'h0, 32'hBEEF1234, 0);
        do_access("sb_101", SB, 32'h101, 32'h000000A5, 32'h0, 0);
        do_access("sh_102", SH, 32'h102, 32'h1234ABCD, 32'h0, 1);
        do_access("lw_wait3", LW, 32'h200, 32'h0, 32'hCAFEF00D, 3);
        do_access("lw_tmo", LW, 32'h204, 32'h0, 32'h12345678, 9);
        do_access("sw_tmo", SW, 32'h208, 32'h55AA55AA, 32'h0, WL);
        do_access("lw_102", LW, 32'h102, 32'h0, 32'h89ABCDEF, 0);
        do_access("lh_101", LH, 32'h101, 32'h0, 32'h0000F00F, 0);
        do_access("unsup", BAD, 32'h300, 32'hFFFFFFFF, 32'h0, 0);

        for (int i = 0; i < 80; i++) begin
            do_access($sformatf("rnd%0d", i), ops[$urandom_range(0, 8)],
                      $urandom, $urandom, $urandom, $urandom_range(0, 5));
        end

        bus.req_valid = 1'b1;
        bus.req_opcode = LW;
        bus.req_addr = 32'h400;
        bus.avm_waitrequest = 1'b1;
        @(negedge clk);
        chk("rst_bus read", 32'(bus.avm_read), 32'd1);
        bus.req_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        chk_reset_vals("rst_bus");
        reset = 1'b0;
        bus.avm_waitrequest = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_quiet", 32'({bus.resp_valid, bus.avm_read}), 32'd0);
        end
        do_access("post_rst", LHU, 32'h402, 32'h0, 32'h7FFF8001, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
